// File: rtl/shift_issue.sv
// rtl/shift_issue.sv - issue/collect stage in front of the shift16 datapath
//
// Purpose: issues valid/ready requests onto shift16's a/distance inputs, tracks
// each one through the fixed LATENCY with a valid shift register, and captures
// the unqualified sh_r_i result into a first-word-fall-through FIFO. Credits
// (in-flight + buffered < FIFO_DEPTH) guarantee the FIFO can never overflow, so
// results are never dropped under backpressure and stay in accept order.
//
// Optional feature macro: SHIFT_ISSUE_TAG_EN (carry in_tag_i alongside results).
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   in_valid_i/in_ready_o             request handshake
//   in_a_i, in_dist_i, in_tag_i       operand, shift distance, tag
//   sh_a_o, sh_distance_o             registered drive to shift16
//   sh_r_i                            shift16 result (no valid of its own)
//   out_valid_o/out_ready_i           result handshake (FIFO head)
//   out_r_o, out_tag_o                head result and tag
//   busy_o                            any request in flight or buffered
module shift_issue #(
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] in_a_i,
  input  logic [3:0]  in_dist_i,
  input  logic [3:0]  in_tag_i,
  output logic [15:0] sh_a_o,
  output logic [3:0]  sh_distance_o,
  input  logic [31:0] sh_r_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_r_o,
  output logic [3:0]  out_tag_o,
  output logic        busy_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(LATENCY + 2);
`ifdef SHIFT_ISSUE_TAG_EN
  localparam int FW = 36;
`else
  localparam int FW = 32;
`endif

  logic [15:0]    sh_a_q, sh_a_d;
  logic [3:0]     sh_dist_q, sh_dist_d;
  logic [LATENCY:0] trk_q, trk_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [FW-1:0]  mem_q [FIFO_DEPTH];
  logic [FW-1:0]  push_data, head;
  logic [IW-1:0]  inflight;
  logic [31:0]    credits_used;
  logic           accept, push, pop;

  // Number of requests currently inside the datapath.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= LATENCY; i++) begin
      inflight = inflight + IW'(trk_q[i]);
    end
  end

  // Credits come from registered state only; rst_i forces not-ready.
  assign credits_used = 32'(inflight) + 32'(count_q);
  assign in_ready_o   = !rst_i && (credits_used < 32'(FIFO_DEPTH));

  assign accept      = in_valid_i && in_ready_o;
  assign push        = trk_q[LATENCY];
  assign out_valid_o = (count_q != '0);
  assign pop         = out_valid_o && out_ready_i;
  assign busy_o      = (inflight != '0) || (count_q != '0);

`ifdef SHIFT_ISSUE_TAG_EN
  logic [3:0] tag_q [LATENCY+1];

  // Tag shift register runs in lockstep with the valid tracker.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i <= LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= in_tag_i;
      for (int i = 1; i <= LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign push_data = {tag_q[LATENCY], sh_r_i};
  assign out_tag_o = out_valid_o ? head[35:32] : 4'd0;
`else
  logic unused_tag;
  assign unused_tag = ^in_tag_i;
  assign push_data  = sh_r_i;
  assign out_tag_o  = 4'd0;
`endif

  assign head    = mem_q[rd_ptr_q];
  assign out_r_o = out_valid_o ? head[31:0] : 32'd0;

  assign sh_a_o        = sh_a_q;
  assign sh_distance_o = sh_dist_q;

  always_comb begin
    sh_a_d    = sh_a_q;
    sh_dist_d = sh_dist_q;
    if (accept) begin
      sh_a_d    = in_a_i;
      sh_dist_d = in_dist_i;
    end
    trk_d    = {trk_q[LATENCY-1:0], accept};
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_a_q   <= '0;
      sh_dist_q <= '0;
      trk_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      sh_a_q   <= sh_a_d;
      sh_dist_q <= sh_dist_d;
      trk_q    <= trk_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible behind count_q.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: doc/shift_issue.md
# shift_issue

Issue and collect stage for the 16-bit shift datapath (`shift16` plus its `mul16` multiplier). It sits directly upstream of `shift16`, driving its `a`/`distance` inputs from a valid/ready request port. It also collects `shift16`'s 32-bit `r` output, which carries no valid signal. The block tracks each request through the fixed datapath latency and buffers results in a small FIFO, so results are never lost under downstream backpressure and ordering is preserved.

## Interface
- `LATENCY`, default 2: edges from the `sh_a`/`sh_distance` update to `sh_r` being valid. Must equal the shift datapath's register depth. Legal range ≥ 1.
- `FIFO_DEPTH`, default 8: result FIFO entries. Must be a power of 2 and ≥ 2.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: block accepts the request this cycle.
- `in_a` in 16: operand.
- `in_dist` in 4: shift distance, 0–15.
- `in_tag` in 4: request tag (used only with `SHIFT_ISSUE_TAG_EN`).
- `sh_a` out 16: to `shift16.a`. Registered.
- `sh_distance` out 4: to `shift16.distance`. Registered.
- `sh_r` in 32: from `shift16.r`.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: consumer takes the head.
- `out_r` out 32: result, equal to `in_a << in_dist`, zero-extended.
- `out_tag` out 4: tag of the result.
- `busy` out 1: any request in flight or buffered.

## Operation
- Accept happens when `in_valid && in_ready` at a rising edge (edge E0). At E0:
  - `sh_a <= in_a`
  - `sh_distance <= in_dist`
  - a 1 enters stage 0 of a `LATENCY+1`-stage valid tracker.
- With no accept, `sh_a` and `sh_distance` hold their last values, and a 0 enters the tracker.
- `sh_r` is valid during the cycle after edge E0+LATENCY. The result is written into the FIFO at edge E0+LATENCY+1, when the tracker's last stage is 1. `sh_r` is ignored whenever the tracker's last stage is 0.
- Credit rule: `in_ready = !rst && (inflight + count) < FIFO_DEPTH`.
  - `inflight` is the number of 1s in the tracker.
  - `count` is the FIFO occupancy.
  - Both are computed from registered state only. There is no combinational path from `out_ready` or `in_valid` to `in_ready`.
- Because of the credit rule, the FIFO never overflows. A tracker write into a full FIFO is unreachable. Verification asserts this.
- FIFO behaviour:
  - First-word fall-through: `out_valid = (count != 0)`, and `out_r`/`out_tag` show the head.
  - Pop happens on `out_valid && out_ready`.
  - A simultaneous push and pop leaves `count` unchanged. This includes `count == FIFO_DEPTH` with a pop, and `count == 0`, where a push plus pop is impossible because `out_valid` is 0.
  - Pointers are `log2(FIFO_DEPTH)` bits wide and wrap naturally.
- `busy = (inflight != 0) || (count != 0)`.
- Reset values: `sh_a = 0`, `sh_distance = 0`, tracker all 0, FIFO pointers and count 0, `out_valid = 0`, `out_r = 0`, `out_tag = 0`, `busy = 0`, `in_ready = 0`.
- Reset mid-operation: all in-flight and buffered results are discarded. Results arriving on `sh_r` after reset are never captured. No output is produced for requests accepted before reset.
- Results leave in accept order. There is no reordering.

## Timing
- Accept-to-`out_valid` latency is LATENCY+1 edges when the FIFO is empty: `out_valid` goes high in the cycle after edge E0+LATENCY+1. For the default LATENCY = 2, that is 3 edges.
- Throughput is one request per cycle sustained when `FIFO_DEPTH ≥ LATENCY+3` and `out_ready` is held high.
- With `out_ready` low, at most FIFO_DEPTH requests are accepted before `in_ready` drops. `in_ready` rises again in the cycle after the pop edge.
- `in_ready` is low during the reset cycle and high in the first cycle after reset deasserts.

## Configuration
- `SHIFT_ISSUE_TAG_EN`, defined: `in_tag` is carried through a tag pipeline parallel to the valid tracker, the FIFO is 36 bits wide, and `out_tag` reports the tag of the head result.
- `SHIFT_ISSUE_TAG_EN`, undefined: `in_tag` is ignored, the FIFO is 32 bits wide, and `out_tag` is tied to 0.

## Test plan
- Single request, `in_a = 0x0003`, `in_dist = 4`, `out_ready = 1`: `out_valid` is high for exactly 1 cycle, 3 edges after accept, with `out_r = 0x00000030`.
- Edge operands:
  - `in_a = 0xFFFF`, `in_dist = 15` → `out_r = 0x7FFF8000`.
  - `in_a = 0x8001`, `in_dist = 0` → `out_r = 0x00008001`.
- Back-to-back run: 16 requests with `in_a = i`, `in_dist = i % 16`, and `out_ready = 1`. `in_ready` stays high throughout, and the outputs are `i << (i % 16)` in order, one per cycle.
- Backpressure: `out_ready = 0` and `in_valid` held high. Exactly 8 accepts occur, then `in_ready` goes low and `count` stays 8. After `out_ready = 1`, all 8 results drain in order with none lost.
- Reset mid-flight: assert `rst` for 1 cycle, 1 edge after accepting 2 requests. Afterwards `out_valid` stays 0, `busy` is 0, and a new request `0x0001`/`3` returns `0x00000008`.
- Tag build (`SHIFT_ISSUE_TAG_EN`): issue tags 0xA, 0x5, 0xF while `out_ready` toggles every cycle. `out_tag` follows the sequence 0xA, 0x5, 0xF in order, each paired with its correct `out_r`.
